uart_echo_resp: RTL and testbench
=================================

# uart_echo_resp

UART responder forming the far end of the board's byte loopback link. It deserializes 8N1 frames arriving on `RX`, buffers the bytes in a 4-entry FIFO, and re-serializes each one on `TX`. The same byte is also presented on `rx_byte` so it can drive the LEDs. The block sits opposite the push-button/counter byte source: it answers every byte sent, and it can stall its own replies under `tx_hold`.

## Interface
- `BAUD_DIV`, default 434, clk cycles per bit (50 MHz / 115200). Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous serial input, idle high.
- `tx_hold`  in  1  when 1, no new TX frame starts; a frame already in progress completes.
- `TX`  out  1  serial output, idle high.
- `rx_byte`  out  8  last byte received with a valid stop bit.
- `rx_rdy`  out  1  one-cycle pulse when `rx_byte` updates.
- `fifo_cnt`  out  3  FIFO occupancy, 0..4.
- `tx_busy`  out  1  high while the TX FSM is outside IDLE.
- `ovf`  out  1  sticky; a byte was dropped because the FIFO was full.
- `frm_err`  out  1  sticky; a stop bit was sampled low.

## Operation
- Reset values: `TX`=1, `rx_byte`=0x00, `rx_rdy`=0, `fifo_cnt`=0, `tx_busy`=0, `ovf`=0, `frm_err`=0. Both synchronizer flops reset to 1. Both FSMs reset to IDLE.
- `RX` passes through a 2-flop synchronizer (`rxs`). All receive decisions use `rxs`.
- RX FSM states are IDLE, START, DATA and STOP. A single baud counter and a bit counter (0..7) serve all of them.
  - IDLE → START when `rxs`=0.
  - START: count `BAUD_DIV/2` cycles, then sample `rxs`. If 0, go to DATA. If 1, the start was a glitch: go to IDLE with no side effects.
  - DATA: every `BAUD_DIV` cycles, shift `rxs` in LSB-first. After bit 7, go to STOP.
  - STOP: after `BAUD_DIV` cycles, sample `rxs`.
    - Sample 1: load `rx_byte`, pulse `rx_rdy`, push the byte to the FIFO.
    - Sample 0: set `frm_err`, do not push, do not update `rx_byte`.
    - Either way, go to IDLE. IDLE is entered mid stop bit.
- FIFO: 4 entries, pointers wrap modulo 4.
  - Push when full: the byte is discarded, `ovf` is set, and `rx_byte`/`rx_rdy` still update.
  - Push and pop in the same cycle: pop first, so a push to a full FIFO succeeds and `fifo_cnt` is unchanged.
  - `ovf` and `frm_err` clear only on `rst`.
- TX FSM states are IDLE, START, DATA and STOP.
  - IDLE → START when `fifo_cnt`≠0 and `tx_hold`=0. On that transition, pop the head entry into the shift register.
  - START drives `TX`=0 for `BAUD_DIV` cycles.
  - DATA drives 8 bits LSB-first, `BAUD_DIV` cycles each.
  - STOP drives `TX`=1 for `BAUD_DIV` cycles, then goes to IDLE.
  - `TX` is a registered output.
- `tx_hold` is sampled only in IDLE.

## Timing
- Push occurs in the cycle after the stop-bit sample. `fifo_cnt` reflects it one cycle later.
- With TX idle and `tx_hold`=0, `TX` falls 3 cycles after the stop-bit sample cycle.
- From `RX` falling edge to the stop-bit sample: 2 sync cycles + `BAUD_DIV/2` + 9×`BAUD_DIV` cycles, ±1.
- TX frame length: exactly 10×`BAUD_DIV` cycles. Back-to-back frames have no idle gap beyond the 1 cycle spent in IDLE.
- Reset asserted mid-frame: both FSMs abort, `TX`=1 on the next edge, FIFO is emptied, partial RX byte is discarded.

## Configuration
- `UART_ECHO_INC_EN` defined: the byte loaded into the TX shift register is the FIFO entry + 1, mod 256 (0xFF → 0x00).
- `UART_ECHO_INC_EN` undefined: the byte is echoed unmodified.
- `rx_byte` always shows the unmodified received value.

## Test plan
- `BAUD_DIV`=8, `tx_hold`=0, send 0xA5 on `RX` → `rx_rdy` pulses once, `rx_byte`=0xA5, `TX` emits 0xA5 (0xA6 with `UART_ECHO_INC_EN`). The TX start edge occurs 3 cycles after the stop sample.
- `RX` low for 3 cycles, then high → no `rx_rdy`, `fifo_cnt`=0, `TX` stays 1.
- Frame 0x3C sent with the stop bit driven 0 → `frm_err`=1, `fifo_cnt`=0, `rx_byte` unchanged, no TX frame.
- `tx_hold`=1, send 0x01..0x05 → `fifo_cnt`=4, `ovf`=1, `rx_byte`=0x05. Release `tx_hold` → `TX` emits 0x01, 0x02, 0x03, 0x04 back-to-back, then `fifo_cnt`=0.
- With the FIFO full and TX popping in the same cycle as a push, send 0xFF → the push is accepted, `ovf` stays 0, and 0xFF is echoed last. With `UART_ECHO_INC_EN`, the echo is 0x00.
- Assert `rst` midway through a TX data bit → next edge: `TX`=1, `tx_busy`=0, `fifo_cnt`=0, flags 0. The next received byte echoes normally.

Source files
------------

// File: rtl/uart_echo_resp.sv
// -----------------------------------------------------------------------------
// uart_echo_resp
//
// Far end of the board byte loopback link. Receives 8N1 frames on RX, keeps
// the received bytes in a 4-entry FIFO and sends each one back on TX. The
// last good byte is also held on rx_byte for the LEDs. tx_hold stalls new
// replies without cutting a frame that is already on the wire.
//
// Build option:
//   UART_ECHO_INC_EN  defined   -> each reply is the received byte + 1 (mod 256)
//                     undefined -> each reply is the received byte unchanged
//
// Parameter:
//   BAUD_DIV   clk cycles per bit; even and >= 4 (434 = 50 MHz / 115200)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   RX        in   asynchronous serial input, idle high
//   tx_hold   in   1 = do not start a new TX frame
//   TX        out  serial output, idle high (registered)
//   rx_byte   out  last byte received with a good stop bit
//   rx_rdy    out  one-cycle pulse when rx_byte updates
//   fifo_cnt  out  FIFO occupancy 0..4
//   tx_busy   out  TX FSM outside IDLE
//   ovf       out  sticky: a byte was dropped on a full FIFO
//   frm_err   out  sticky: a stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_echo_resp #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       tx_hold,
    output logic       TX,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic [2:0] fifo_cnt,
    output logic       tx_busy,
    output logic       ovf,
    output logic       frm_err
);

    localparam int             CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  FULL_MAX = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  HALF_MAX = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ---------------- receive side ----------------
    logic          r_rx_meta;
    logic          r_rxs;
    uart_state_t   r_rx_state;
    uart_state_t   w_rx_state_nxt;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          r_push_pend;
    logic          w_rx_cnt_clr;
    logic          w_rx_shift;
    logic          w_rx_stop_smp;

    // ---------------- FIFO ----------------
    logic [7:0]    r_mem [4];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_fifo_head;
    logic [7:0]    w_tx_load;

    // ---------------- transmit side ----------------
    uart_state_t   r_tx_state;
    uart_state_t   w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sh;
    logic          w_tx_cnt_clr;
    logic          w_tx_shift;
    logic          w_tx_val;

    // Two-flop synchronizer for the asynchronous RX line, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
        end
    end

    // RX next-state logic and the strobes that drive the RX datapath.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_clr   = 1'b0;
        w_rx_shift     = 1'b0;
        w_rx_stop_smp  = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_clr = 1'b1;
                if (!r_rxs) begin
                    w_rx_state_nxt = ST_START;
                end else begin
                    w_rx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (r_rx_cnt == HALF_MAX) begin
                    w_rx_cnt_clr   = 1'b1;
                    w_rx_state_nxt = r_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == FULL_MAX) begin
                    w_rx_cnt_clr = 1'b1;
                    w_rx_shift   = 1'b1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = ST_STOP;
                    end else begin
                        w_rx_state_nxt = ST_DATA;
                    end
                end else begin
                    w_rx_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                // Return to IDLE mid stop bit so the next start edge is not missed.
                if (r_rx_cnt == FULL_MAX) begin
                    w_rx_cnt_clr   = 1'b1;
                    w_rx_stop_smp  = 1'b1;
                    w_rx_state_nxt = ST_IDLE;
                end else begin
                    w_rx_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_rx_cnt_clr   = 1'b1;
                w_rx_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RX state register, baud/bit counters, shifter and received-byte outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= ST_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= 3'd0;
            r_rx_sh     <= 8'h00;
            r_push_pend <= 1'b0;
            rx_byte     <= 8'h00;
            rx_rdy      <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_nxt;
            r_rx_cnt    <= w_rx_cnt_clr ? '0 : r_rx_cnt + 1'b1;
            rx_rdy      <= 1'b0;
            r_push_pend <= 1'b0;
            if (r_rx_state == ST_IDLE) begin
                r_rx_bit <= 3'd0;
            end else if (w_rx_shift) begin
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (w_rx_shift) begin
                r_rx_sh <= {r_rxs, r_rx_sh[7:1]};
            end
            if (w_rx_stop_smp) begin
                if (r_rxs) begin
                    rx_byte     <= r_rx_sh;
                    rx_rdy      <= 1'b1;
                    r_push_pend <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

    // Pop happens on the TX IDLE->START step; a pop frees room for a push
    // in the same cycle, so a full FIFO still accepts that byte.
    assign w_pop       = (r_tx_state == ST_IDLE) && (fifo_cnt != 3'd0) && !tx_hold;
    assign w_push      = r_push_pend && ((fifo_cnt != 3'd4) || w_pop);
    assign w_fifo_head = r_mem[r_rd_ptr];

`ifdef UART_ECHO_INC_EN
    assign w_tx_load = w_fifo_head + 8'd1;
`else
    assign w_tx_load = w_fifo_head;
`endif

    // FIFO storage; the byte being pushed is the one just placed on rx_byte.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            fifo_cnt <= 3'd0;
            ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (r_push_pend && !w_push) begin
                ovf <= 1'b1;
            end
        end
    end

    // TX next-state logic and the value TX takes on the next edge.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_clr   = 1'b0;
        w_tx_shift     = 1'b0;
        w_tx_val       = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_clr = 1'b1;
                if (w_pop) begin
                    w_tx_state_nxt = ST_START;
                    w_tx_val       = 1'b0;
                end else begin
                    w_tx_state_nxt = ST_IDLE;
                    w_tx_val       = 1'b1;
                end
            end
            ST_START: begin
                if (r_tx_cnt == FULL_MAX) begin
                    w_tx_cnt_clr   = 1'b1;
                    w_tx_state_nxt = ST_DATA;
                    w_tx_val       = r_tx_sh[0];
                end else begin
                    w_tx_val       = 1'b0;
                end
            end
            ST_DATA: begin
                // On a bit boundary the shifter moves on, so the next bit is sh[1].
                if (r_tx_cnt == FULL_MAX) begin
                    w_tx_cnt_clr = 1'b1;
                    w_tx_shift   = 1'b1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = ST_STOP;
                        w_tx_val       = 1'b1;
                    end else begin
                        w_tx_val       = r_tx_sh[1];
                    end
                end else begin
                    w_tx_val = r_tx_sh[0];
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == FULL_MAX) begin
                    w_tx_cnt_clr   = 1'b1;
                    w_tx_state_nxt = ST_IDLE;
                end else begin
                    w_tx_state_nxt = ST_STOP;
                end
                w_tx_val = 1'b1;
            end
            default: begin
                w_tx_cnt_clr   = 1'b1;
                w_tx_state_nxt = ST_IDLE;
                w_tx_val       = 1'b1;
            end
        endcase
    end

    // TX state register, counters, shifter and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'h00;
            TX         <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_clr ? '0 : r_tx_cnt + 1'b1;
            if (r_tx_state == ST_IDLE) begin
                r_tx_bit <= 3'd0;
            end else if (w_tx_shift) begin
                r_tx_bit <= r_tx_bit + 3'd1;
            end
            if (w_pop) begin
                r_tx_sh <= w_tx_load;
            end else if (w_tx_shift) begin
                r_tx_sh <= {1'b0, r_tx_sh[7:1]};
            end
            TX      <= w_tx_val;
            tx_busy <= (w_tx_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_echo_resp.sv
`timescale 1ns/1ps
module tb_uart_echo_resp;

    localparam int B     = 8;
    localparam int FRAME = 10 * B;
`ifdef UART_ECHO_INC_EN
    localparam logic [7:0] INC = 8'd1;
`else
    localparam logic [7:0] INC = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       tx_hold = 1'b0;
    logic       TX;
    logic [7:0] rx_byte;
    logic       rx_rdy;
    logic [2:0] fifo_cnt;
    logic       tx_busy;
    logic       ovf;
    logic       frm_err;

    uart_echo_resp #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .tx_hold(tx_hold), .TX(TX),
        .rx_byte(rx_byte), .rx_rdy(rx_rdy), .fifo_cnt(fifo_cnt),
        .tx_busy(tx_busy), .ovf(ovf), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rst_epoch = 0;
    int rx_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) rst_epoch <= rst_epoch + 1;

    // Reference: a reply is the received byte, optionally incremented.
    function automatic logic [7:0] echo_of(input logic [7:0] b);
        return b + INC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX line decoder: samples each bit in its middle.
    logic [7:0] cap_byte[$];
    int         cap_start[$];
    logic       cap_stop[$];
    int         tx_starts = 0;
    int         mon_s, mon_ep;
    logic [7:0] mon_d;
    logic       mon_stp;
    initial begin
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                mon_s  = cyc;
                mon_ep = rst_epoch;
                tx_starts++;
                repeat (B/2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (B) @(negedge clk);
                    mon_d[k] = TX;
                end
                repeat (B) @(negedge clk);
                mon_stp = TX;
                if (mon_ep == rst_epoch) begin
                    cap_byte.push_back(mon_d);
                    cap_start.push_back(mon_s);
                    cap_stop.push_back(mon_stp);
                end
            end
        end
    end

    // Received-byte log from rx_rdy pulses.
    int         rdy_cnt = 0;
    logic [7:0] rdy_q[$];
    always @(negedge clk) begin
        if (rx_rdy === 1'b1) begin
            rdy_cnt++;
            rdy_q.push_back(rx_byte);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        rx_fall_cyc = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (cap_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_seen", cap_byte.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n0, r0, base, delta, found;
        logic [7:0] b;
        logic       stp, any_bad;
        logic [7:0] q[$];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_TX", TX, 1'b1);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_rx_rdy", rx_rdy, 1'b0);
        chk("rst_fifo_cnt", fifo_cnt, 3'd0);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_frm_err", frm_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte echo and its latency
        send_byte(8'hA5, 1'b1);
        wait_frames(1, 2 * FRAME);
        chk("a5_rdy_cnt", rdy_cnt, 1);
        chk("a5_rdy_byte", rdy_q[0], 8'hA5);
        chk("a5_rx_byte", rx_byte, 8'hA5);
        chk("a5_echo", cap_byte[0], echo_of(8'hA5));
        chk("a5_stop", cap_stop[0], 1'b1);
        delta = cap_start[0] - rx_fall_cyc;
        chk("a5_tx_latency_window", (delta >= 2 + B/2 + 9*B + 3 - 1) && (delta <= 2 + B/2 + 9*B + 3 + 1), 1'b1);
        repeat (2 * B) @(negedge clk);
        chk("a5_fifo_empty", fifo_cnt, 3'd0);
        chk("a5_tx_idle", tx_busy, 1'b0);

        // Short low glitch on RX is not a frame
        base = tx_starts;
        r0   = rdy_cnt;
        @(negedge clk);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (3 * B) @(negedge clk);
        chk("glitch_rdy", rdy_cnt, r0);
        chk("glitch_fifo", fifo_cnt, 3'd0);
        chk("glitch_tx_starts", tx_starts, base);
        chk("glitch_TX", TX, 1'b1);

        // Framing error: bad stop bit
        send_byte(8'h3C, 1'b0);
        repeat (2 * B) @(negedge clk);
        chk("ferr_flag", frm_err, 1'b1);
        chk("ferr_fifo", fifo_cnt, 3'd0);
        chk("ferr_rx_byte", rx_byte, 8'hA5);
        chk("ferr_rdy", rdy_cnt, r0);
        repeat (12 * B) @(negedge clk);
        chk("ferr_no_tx", tx_starts, base);

        // Hold replies, overfill the FIFO, then release
        tx_hold = 1'b1;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (2 * B) @(negedge clk);
        chk("hold_fifo_full", fifo_cnt, 3'd4);
        chk("hold_ovf", ovf, 1'b1);
        chk("hold_rx_byte", rx_byte, 8'h05);
        chk("hold_rdy_cnt", rdy_cnt, r0 + 5);
        chk("hold_tx_idle", tx_busy, 1'b0);
        n0 = cap_byte.size();
        tx_hold = 1'b0;
        wait_frames(n0 + 4, 5 * FRAME);
        repeat (3 * B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("hold_echo", cap_byte[n0 + i], echo_of(8'(i + 1)));
            chk("hold_stop", cap_stop[n0 + i], 1'b1);
        end
        chk("hold_b2b_gap", cap_start[n0 + 1] - cap_start[n0], FRAME + 1);
        chk("hold_b2b_gap2", cap_start[n0 + 3] - cap_start[n0 + 2], FRAME + 1);
        chk("hold_drained", fifo_cnt, 3'd0);
        chk("hold_only4", cap_byte.size(), n0 + 4);

        // Reset in the middle of a TX data bit
        tx_hold = 1'b1;
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        base = tx_starts;
        tx_hold = 1'b0;
        for (int k = 0; k < 20 && tx_starts == base; k++) @(negedge clk);
        chk("mid_tx_started", tx_starts, base + 1);
        repeat (B + B/2) @(negedge clk);
        chk("mid_tx_busy", tx_busy, 1'b1);
        chk("mid_fifo", fifo_cnt, 3'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_TX", TX, 1'b1);
        chk("mrst_tx_busy", tx_busy, 1'b0);
        chk("mrst_fifo", fifo_cnt, 3'd0);
        chk("mrst_ovf", ovf, 1'b0);
        chk("mrst_frm_err", frm_err, 1'b0);
        chk("mrst_rx_byte", rx_byte, 8'h00);
        rst = 1'b0;
        repeat (12 * B) @(negedge clk);
        n0 = cap_byte.size();
        b = 8'($urandom);
        send_byte(b, 1'b1);
        wait_frames(n0 + 1, 2 * FRAME);
        chk("post_rst_echo", cap_byte[n0], echo_of(b));
        chk("post_rst_rx_byte", rx_byte, b);

        // Full FIFO, push and pop in the same cycle
        repeat (2 * B) @(negedge clk);
        tx_hold = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'($urandom));
            send_byte(q[i], 1'b1);
        end
        repeat (2 * B) @(negedge clk);
        chk("pp_fifo_full", fifo_cnt, 3'd4);
        chk("pp_ovf_before", ovf, 1'b0);
        n0 = cap_byte.size();
        found = 0;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                for (int k = 0; k < 12 * B && found == 0; k++) begin
                    @(negedge clk);
                    if (rx_rdy === 1'b1) begin
                        tx_hold = 1'b0;
                        found = 1;
                    end
                end
                tx_hold = 1'b0;
            end
        join
        chk("pp_rdy_seen", found, 1);
        repeat (2) @(negedge clk);
        chk("pp_ovf_after", ovf, 1'b0);
        chk("pp_fifo_cnt", fifo_cnt, 3'd4);
        wait_frames(n0 + 5, 6 * FRAME);
        for (int i = 0; i < 4; i++) chk("pp_echo", cap_byte[n0 + i], echo_of(q[i]));
        chk("pp_echo_last", cap_byte[n0 + 4], echo_of(8'hFF));

        // Random bytes with random gaps and occasional bad stop bits
        repeat (2 * B) @(negedge clk);
        rdy_q.delete();
        q.delete();
        any_bad = 1'b0;
        n0 = cap_byte.size();
        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_byte(b, stp);
            if (stp) q.push_back(b);
            else any_bad = 1'b1;
            repeat ($urandom_range(3, 30)) @(negedge clk);
        end
        wait_frames(n0 + q.size(), (q.size() + 1) * (FRAME + 2));
        repeat (2 * B) @(negedge clk);
        chk("rnd_rdy_count", rdy_q.size(), q.size());
        for (int i = 0; i < q.size(); i++) begin
            chk("rnd_rx_byte", rdy_q[i], q[i]);
            chk("rnd_echo", cap_byte[n0 + i], echo_of(q[i]));
        end
        chk("rnd_frm_err", frm_err, any_bad);
        chk("rnd_ovf", ovf, 1'b0);
        chk("rnd_fifo_empty", fifo_cnt, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
